pim_weight_writer: RTL and testbench

Crossbar weight programmer for the PIM convolution path: the write-side counterpart of the bit-serial conv read engine. It accepts signed-agnostic WEIGHT_P-bit weights over a valid/ready stream in column-major order, splits each into high and low halves, assembles one full crossbar column per half, and programs the H and L crossbar arrays column by column with a write/acknowledge handshake. It sits between the weight-load DMA and the crossbar arrays that the conv engine later reads by address.

---
 rtl/pim_weight_writer.sv | 112 +++++++++++
 tb/tb_pim_weight_writer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/pim_weight_writer.sv
// Crossbar weight programmer: collects one column of WEIGHT_P-bit weights,
// splits them into high/low halves and writes the H and L arrays column by column.
module pim_weight_writer #(
    parameter int INPUT_SIZE = 100,
    parameter int WEIGHT_P   = 16,
    parameter int DEPTH      = 100,
    parameter int AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start,
    input  logic                               in_valid,
    input  logic [WEIGHT_P-1:0]                in_weight,
    output logic                               in_ready,
    output logic                               wr_en,
    output logic [AW-1:0]                      wr_addr,
    output logic [INPUT_SIZE*(WEIGHT_P/2)-1:0] wr_data_H,
    output logic [INPUT_SIZE*(WEIGHT_P/2)-1:0] wr_data_L,
    input  logic                               wr_ack,
    output logic                               busy,
    output logic                               done
);
    localparam int HP = WEIGHT_P / 2;
    localparam int RW = (INPUT_SIZE > 1) ? $clog2(INPUT_SIZE) : 1;
    localparam logic [RW-1:0] LAST_ROW = RW'(INPUT_SIZE - 1);
    localparam logic [AW-1:0] LAST_COL = AW'(DEPTH - 1);

    typedef enum logic [2:0] {IDLE, FILL, WRITE, WAIT_ACK, DONE} state_t;

    state_t        state_q, state_d;
    logic [RW-1:0] row_cnt, row_d;
    logic [AW-1:0] col_cnt, col_d;
    logic          accept;

    logic [INPUT_SIZE-1:0][HP-1:0] buf_h;
    logic [INPUT_SIZE-1:0][HP-1:0] buf_l;

    assign accept = (state_q == FILL) && in_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            row_cnt <= '0;
            col_cnt <= '0;
        end else begin
            state_q <= state_d;
            row_cnt <= row_d;
            col_cnt <= col_d;
        end
    end

    always_comb begin
        state_d = state_q;
        row_d   = row_cnt;
        col_d   = col_cnt;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = FILL;
                    row_d   = '0;
                    col_d   = '0;
                end
            end
            FILL: begin
                if (in_valid) begin
                    if (row_cnt == LAST_ROW) begin
                        state_d = WRITE;
                        row_d   = '0;
                    end else begin
                        row_d = row_cnt + RW'(1);
                    end
                end
            end
            WRITE:    state_d = WAIT_ACK;
            WAIT_ACK: begin
                if (wr_ack) begin
                    if (col_cnt == LAST_COL) begin
                        state_d = DONE;
                    end else begin
                        col_d   = col_cnt + AW'(1);
                        state_d = FILL;
                    end
                end
            end
            DONE:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Column buffer doubles as the write data register: it only moves on
    // accepted beats, so it stays stable across WRITE and WAIT_ACK.
    for (genvar r = 0; r < INPUT_SIZE; r++) begin : g_row
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                buf_h[r] <= '0;
                buf_l[r] <= '0;
            end else if (accept && row_cnt == RW'(r)) begin
                buf_h[r] <= in_weight[WEIGHT_P-1:HP];
                buf_l[r] <= in_weight[HP-1:0];
            end
        end
    end

    assign in_ready  = (state_q == FILL);
    assign wr_en     = (state_q == WRITE);
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign wr_addr   = col_cnt;
    assign wr_data_H = buf_h;
    assign wr_data_L = buf_l;

endmodule

// File: tb/tb_pim_weight_writer.sv
// Bench for pim_weight_writer: column-level reference model with randomized
// weights, valid gaps and ack delays, plus a 1x1 instance for the minimal case.
module tb_pim_weight_writer;
    localparam int IS = 4;
    localparam int WP = 8;
    localparam int D  = 3;
    localparam int HP = WP / 2;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 start = 1'b0, in_valid = 1'b0, wr_ack = 1'b0;
    logic [WP-1:0]        in_weight = '0;
    logic                 in_ready, wr_en, busy, done;
    logic [1:0]           wr_addr;
    logic [IS*HP-1:0]     wr_data_H, wr_data_L;

    logic                 s_start = 1'b0, s_in_valid = 1'b0, s_wr_ack = 1'b0;
    logic [WP-1:0]        s_in_weight = '0;
    logic                 s_in_ready, s_wr_en, s_busy, s_done;
    logic [0:0]           s_wr_addr;
    logic [HP-1:0]        s_wr_data_H, s_wr_data_L;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pim_weight_writer #(.INPUT_SIZE(IS), .WEIGHT_P(WP), .DEPTH(D)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_weight(in_weight),
        .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data_H(wr_data_H),
        .wr_data_L(wr_data_L), .wr_ack(wr_ack), .busy(busy), .done(done)
    );

    pim_weight_writer #(.INPUT_SIZE(1), .WEIGHT_P(WP), .DEPTH(1)) dut_s (
        .clk(clk), .rst(rst), .start(s_start), .in_valid(s_in_valid), .in_weight(s_in_weight),
        .in_ready(s_in_ready), .wr_en(s_wr_en), .wr_addr(s_wr_addr), .wr_data_H(s_wr_data_H),
        .wr_data_L(s_wr_data_L), .wr_ack(s_wr_ack), .busy(s_busy), .done(s_done)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, 64'(in_ready), 64'd0);
        chk({tag, "_wr_en"},    64'(wr_en),    64'd0);
        chk({tag, "_wr_addr"},  64'(wr_addr),  64'd0);
        chk({tag, "_data_H"},   64'(wr_data_H), 64'd0);
        chk({tag, "_data_L"},   64'(wr_data_L), 64'd0);
        chk({tag, "_busy"},     64'(busy),     64'd0);
        chk({tag, "_done"},     64'(done),     64'd0);
    endtask

    // mode 0: weights 1..IS*D back to back; 1: 0xF5 with in_valid toggling;
    // 2: random weights with random valid gaps.
    task automatic session(input int mode, input int ack_dly, input bit spurious,
                           input bit start_noise, input int abort_col, input int abort_row);
        logic [WP-1:0]    w [D][IS];
        logic [IS*HP-1:0] eh, el;
        int               t, tries;
        bit               ph, v, acc;
        for (int c = 0; c < D; c++)
            for (int r = 0; r < IS; r++)
                case (mode)
                    0:       w[c][r] = WP'(c * IS + r + 1);
                    1:       w[c][r] = 8'hF5;
                    default: w[c][r] = WP'($urandom_range(0, 255));
                endcase
        start = 1'b1;
        tick();
        start = 1'b0;
        t  = 1;
        ph = 1'b0;
        for (int c = 0; c < D; c++) begin
            for (int r = 0; r < IS; r++) begin
                if (c == abort_col && r == abort_row) begin
                    chk("abort_pre_ready", 64'(in_ready), 64'd1);
                    #2 rst = 1'b1;
                    #1 chk_reset_outputs("async_rst");
                    tick();
                    tick();
                    chk("rst_held_wr_en", 64'(wr_en), 64'd0);
                    rst = 1'b0;
                    in_valid = 1'b1;
                    tick();
                    chk("post_rst_idle_ready", 64'(in_ready), 64'd0);
                    chk("post_rst_idle_busy", 64'(busy), 64'd0);
                    in_valid = 1'b0;
                    return;
                end
                tries = 0;
                do begin
                    v  = (mode == 1) ? ph :
                         (mode == 2) ? (($urandom_range(0, 1) == 1) || tries > 3) : 1'b1;
                    ph = ~ph;
                    if (start_noise && c == 1 && r == 1) start = 1'b1;
                    in_valid  = v;
                    in_weight = v ? w[c][r] : 8'h5A;
                    chk("fill_ready", 64'(in_ready), 64'd1);
                    acc = v && in_ready;
                    tick();
                    t++;
                    tries++;
                    start = 1'b0;
                end while (!acc && tries < 40);
                if (!acc) chk("beat_timeout", 64'd0, 64'd1);
            end
            in_valid = 1'b0;
            eh = '0;
            el = '0;
            for (int r = 0; r < IS; r++) begin
                eh = eh | ((IS*HP)'(w[c][r] >> HP) << (HP * r));
                el = el | ((IS*HP)'(w[c][r] % (1 << HP)) << (HP * r));
            end
            chk("write_wr_en",    64'(wr_en),     64'd1);
            chk("write_addr",     64'(wr_addr),   64'(c));
            chk("write_data_H",   64'(wr_data_H), 64'(eh));
            chk("write_data_L",   64'(wr_data_L), 64'(el));
            chk("write_in_ready", 64'(in_ready),  64'd0);
            if (spurious) wr_ack = 1'b1;
            tick();
            t++;
            wr_ack = 1'b0;
            for (int d = 0; d <= ack_dly; d++) begin
                chk("wait_wr_en",    64'(wr_en),     64'd0);
                chk("wait_in_ready", 64'(in_ready),  64'd0);
                chk("wait_addr",     64'(wr_addr),   64'(c));
                chk("wait_data_H",   64'(wr_data_H), 64'(eh));
                chk("wait_data_L",   64'(wr_data_L), 64'(el));
                if (d == ack_dly) wr_ack = 1'b1;
                tick();
                t++;
            end
            wr_ack = 1'b0;
            if (c < D - 1) begin
                chk("next_col_ready", 64'(in_ready), 64'd1);
                chk("next_col_done",  64'(done),     64'd0);
            end else begin
                chk("done_pulse", 64'(done), 64'd1);
                chk("done_busy",  64'(busy), 64'd1);
                if (mode == 0 && ack_dly == 0 && !spurious)
                    chk("done_cycle", 64'(t), 64'(D * (IS + 2) + 1));
                if (start_noise) start = 1'b1;
                tick();
                start = 1'b0;
                chk("idle_done",  64'(done),     64'd0);
                chk("idle_busy",  64'(busy),     64'd0);
                chk("idle_ready", 64'(in_ready), 64'd0);
            end
        end
    endtask

    initial begin
        logic [WP-1:0] sw;
        #1;
        chk_reset_outputs("reset");
        chk("reset_s_busy", 64'(s_busy), 64'd0);
        tick();
        rst = 1'b0;
        tick();

        session(0, 0, 1'b0, 1'b0, -1, -1);
        session(0, 0, 1'b0, 1'b0, -1, -1);
        session(1, 0, 1'b0, 1'b0, -1, -1);

        in_valid  = 1'b1;
        in_weight = 8'hAA;
        wr_ack    = 1'b1;
        repeat (3) begin
            chk("idle_noise_ready", 64'(in_ready), 64'd0);
            chk("idle_noise_busy",  64'(busy),     64'd0);
            chk("idle_noise_wr_en", 64'(wr_en),    64'd0);
            tick();
        end
        in_valid = 1'b0;
        wr_ack   = 1'b0;

        session(2, 10, 1'b1, 1'b1, -1, -1);
        session(2, 0, 1'b0, 1'b0, 1, 2);
        session(0, 0, 1'b0, 1'b0, -1, -1);
        repeat (3) session(2, int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)), 1'b1, -1, -1);

        sw = WP'($urandom_range(0, 255));
        chk("s_idle_busy", 64'(s_busy), 64'd0);
        s_start = 1'b1;
        tick();
        s_start = 1'b0;
        chk("s_fill_busy",  64'(s_busy),     64'd1);
        chk("s_fill_ready", 64'(s_in_ready), 64'd1);
        s_in_valid  = 1'b1;
        s_in_weight = sw;
        tick();
        s_in_valid = 1'b0;
        chk("s_wr_en",  64'(s_wr_en),     64'd1);
        chk("s_addr",   64'(s_wr_addr),   64'd0);
        chk("s_data_H", 64'(s_wr_data_H), 64'(sw >> HP));
        chk("s_data_L", 64'(s_wr_data_L), 64'(sw % 16));
        chk("s_write_busy", 64'(s_busy),  64'd1);
        tick();
        chk("s_wait_wr_en", 64'(s_wr_en), 64'd0);
        chk("s_wait_busy",  64'(s_busy),  64'd1);
        s_wr_ack = 1'b1;
        tick();
        s_wr_ack = 1'b0;
        chk("s_done",      64'(s_done), 64'd1);
        chk("s_done_busy", 64'(s_busy), 64'd1);
        tick();
        chk("s_end_done", 64'(s_done), 64'd0);
        chk("s_end_busy", 64'(s_busy), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
